// File: rtl/onehot_enc_pkg.sv
// Shared definitions for the one-hot/multi-hot line vector to binary index encoder.
package onehot_enc_pkg;

  // Default number of input lines.
  localparam int unsigned N_DEF = 4;

  // Default code width, derived from the line count.
  localparam int unsigned W_DEF = $clog2(N_DEF);

  // IDLE: nothing pending. DRAIN: at least one index still to emit.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage : onehot_enc_pkg

// File: rtl/lsb_index.sv
// Combinational lowest-set-bit locator with a single-bit-set flag.
module lsb_index #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] pend,
  output logic [W-1:0] idx,
  output logic         single
);

  logic found;

  // Scan upward and latch the first set bit; idx is 0 for an empty vector.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend[i] && !found) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  always_comb begin
    single = (pend != '0) && ((pend & (pend - N'(1))) == '0);
  end

endmodule : lsb_index

// File: rtl/onehot_encoder_seq.sv
// Converts each accepted N-bit line vector into one binary index per set bit,
// lowest index first, using valid/ready handshakes on both sides.
module onehot_encoder_seq
  import onehot_enc_pkg::*;
#(
  parameter  int unsigned N = N_DEF,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         err_zero
);

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           err_q, err_d;
  logic [W-1:0]   lsb_idx;
  logic           lsb_single;
  logic           accept;
  logic           consume;

  lsb_index #(
    .N (N),
    .W (W)
  ) u_lsb_index (
    .pend   (pend_q),
    .idx    (lsb_idx),
    .single (lsb_single)
  );

  // Outputs come straight from registered state.
  always_comb begin
    out_valid = (state_q == DRAIN);
    out_code  = lsb_idx;
    out_last  = lsb_single;
    err_zero  = err_q;
  end

  // Handshake qualifiers; the only input-to-output path is out_ready -> in_ready.
  always_comb begin
    in_ready = rst_n && ((state_q == IDLE) || (out_valid && out_ready && lsb_single));
    accept   = in_valid && in_ready;
    consume  = out_valid && out_ready;
  end

  // Next pending set and state: a new word can only arrive once pend is about
  // to empty, so the state simply follows whether anything remains pending.
  always_comb begin
    pend_d = pend_q;
    if (consume) begin
      pend_d = pend_q & (pend_q - N'(1));
    end
    if (accept && (in_vec != '0)) begin
      pend_d = in_vec;
    end
    state_d = (pend_d != '0) ? DRAIN : IDLE;
    err_d   = accept && (in_vec == '0);
  end

  // State, pending vector and zero-word pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

endmodule : onehot_encoder_seq
